// File: rtl/gtob_decoder.sv
// Bit-serial Gray-to-binary decoder with valid/ready handshakes on both sides.
// Decodes MSB first, one bit per clock, and flags codes that are not a single Gray step.
module gtob_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary_out,
  output logic             step_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] dec_q;
  logic [WIDTH-1:0] dec_d;
  logic [WIDTH:0]   decExt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prevGray_q;
  logic             prevValid_q;
  logic             errPend_q;
  logic             errNext;
  logic [WIDTH-1:0] binary_q;
  logic             stepErr_q;
  logic             outValid_q;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = outValid_q;
  assign binary_out = binary_q;
  assign step_err   = stepErr_q;

  // A repeated code (zero bits changed) counts as an error, as does any multi-bit jump.
  assign errNext = prevValid_q && ($countones(gray_in ^ prevGray_q) != 1);

  // The zero guard bit above the MSB lets the top bit use the same XOR rule as the rest.
  assign decExt = {1'b0, dec_q};

  always_comb begin
    dec_d = dec_q;
    for (int j = 0; j < WIDTH; j++) begin
      if (cnt_q == CW'(j)) begin
        dec_d[j] = gray_q[j] ^ decExt[j+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gray_q      <= '0;
      dec_q       <= '0;
      cnt_q       <= '0;
      prevGray_q  <= '0;
      prevValid_q <= 1'b0;
      errPend_q   <= 1'b0;
      binary_q    <= '0;
      stepErr_q   <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            gray_q      <= gray_in;
            dec_q       <= '0;
            cnt_q       <= CW'(WIDTH - 1);
            errPend_q   <= errNext;
            prevGray_q  <= gray_in;
            prevValid_q <= 1'b1;
            state_q     <= DECODE;
          end
        end
        DECODE: begin
          dec_q <= dec_d;
          if (cnt_q == '0) begin
            binary_q   <= dec_d;
            stepErr_q  <= errPend_q;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            stepErr_q  <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gtob_decoder.sv
// Self-checking bench for gtob_decoder: hand vector table, corner sequences and
// randomized codes checked against an arithmetic Gray/step-error model.
module tb_gtob_decoder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] gray_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] binary_out;
  logic         step_err;
  logic         busy;

  int checks;
  int failures;

  logic [W-1:0] modelPrev;
  logic         modelValid;

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         err;
  } vec_t;

  vec_t vecs[$];

  gtob_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary_out(binary_out),
    .step_err  (step_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: binary is the XOR of all right shifts of the Gray code.
  function automatic logic [W-1:0] modelBin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int k = 1; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic modelErr(input logic [W-1:0] g);
    int n;
    logic [W-1:0] x;
    x = g ^ modelPrev;
    n = 0;
    for (int k = 0; k < W; k++) if (x[k]) n++;
    return modelValid && (n != 1);
  endfunction

  task automatic applyStimulus(input logic [W-1:0] g, input logic [W-1:0] expBin,
                               input logic expErr, input int hold, input string tag);
    int lat;
    int waitCnt;
    @(negedge clk);
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    gray_in  = g;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    gray_in  = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      checkOutput({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(W));
    checkOutput({tag, "_binary"}, 32'(binary_out), 32'(expBin));
    checkOutput({tag, "_step_err"}, 32'(step_err), 32'(expErr));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      gray_in  = W'($urandom);
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_binary"}, 32'(binary_out), 32'(expBin));
      checkOutput({tag, "_hold_err"}, 32'(step_err), 32'(expErr));
      checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_drop_err"}, 32'(step_err), 32'd0);
    checkOutput({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_bin_kept"}, 32'(binary_out), 32'(expBin));
    modelPrev  = g;
    modelValid = 1'b1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_binary", 32'(binary_out), 32'd0);
    checkOutput("reset_step_err", 32'(step_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n      = 1'b1;
    modelValid = 1'b0;
    modelPrev  = '0;
  endtask

  initial begin
    logic [W-1:0] g;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    gray_in    = '0;
    modelPrev  = '0;
    modelValid = 1'b0;

    // Full Gray count 0..15, wrap to 0, then the step-error sequence.
    vecs.push_back('{4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0011, 4'b0010, 1'b0});
    vecs.push_back('{4'b0010, 4'b0011, 1'b0});
    vecs.push_back('{4'b0110, 4'b0100, 1'b0});
    vecs.push_back('{4'b0111, 4'b0101, 1'b0});
    vecs.push_back('{4'b0101, 4'b0110, 1'b0});
    vecs.push_back('{4'b0100, 4'b0111, 1'b0});
    vecs.push_back('{4'b1100, 4'b1000, 1'b0});
    vecs.push_back('{4'b1101, 4'b1001, 1'b0});
    vecs.push_back('{4'b1111, 4'b1010, 1'b0});
    vecs.push_back('{4'b1110, 4'b1011, 1'b0});
    vecs.push_back('{4'b1010, 4'b1100, 1'b0});
    vecs.push_back('{4'b1011, 4'b1101, 1'b0});
    vecs.push_back('{4'b1001, 4'b1110, 1'b0});
    vecs.push_back('{4'b1000, 4'b1111, 1'b0});
    vecs.push_back('{4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0011, 4'b0010, 1'b0});
    vecs.push_back('{4'b0110, 4'b0100, 1'b1});
    vecs.push_back('{4'b0110, 4'b0100, 1'b1});
    vecs.push_back('{4'b0111, 4'b0101, 1'b0});

    applyReset();
    applyStimulus(4'b0011, 4'b0010, 1'b0, 0, "first_code");

    applyReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].gray, vecs[i].bin, vecs[i].err, 0, $sformatf("vec%0d", i));
    end

    // Backpressure with in_valid asserted during DONE; the ignored code must not become prev.
    applyStimulus(4'b1000, 4'b1111, modelErr(4'b1000), 7, "backpressure");
    applyStimulus(4'b0000, 4'b0000, 1'b0, 0, "after_bp");

    // Reset on the second DECODE edge discards the in-flight code.
    @(negedge clk);
    gray_in  = 4'b1111;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_binary", 32'(binary_out), 32'd0);
    rst_n = 1'b1;
    modelValid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(4'b0101, 4'b0110, 1'b0, 0, "post_rst_first");

    // A low pulse between edges must leave state and step history intact.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("glitch_binary_kept", 32'(binary_out), 32'b0110);
    applyStimulus(4'b0110, 4'b0100, 1'b1, 1, "glitch_history");

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) g = modelPrev ^ W'(1 << $urandom_range(0, W - 1));
      else g = W'($urandom);
      applyStimulus(g, modelBin(g), modelErr(g), int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/gtob_decoder.md
Name: gtob_decoder

Overview:
Sequential Gray-to-binary decoder: the receive-side counterpart of the combinational binary-to-Gray converter. It accepts a WIDTH-bit Gray code over a valid/ready handshake and decodes it bit-serially, MSB first, one bit per clock. It presents the binary result over a second valid/ready handshake. It also flags any accepted code that is not a single-bit step from the previously accepted code, for checking Gray-coded pointers and counters.

Parameters:
WIDTH, 4, width of Gray input and binary output (WIDTH >= 2)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low; sampled only at rising edge of clk
in_valid  input  1  gray_in holds a code to decode
in_ready  output  1  decoder can accept a code this cycle
gray_in  input  WIDTH  Gray-coded input
out_valid  output  1  binary_out and step_err are valid
out_ready  input  1  consumer accepts the result this cycle
binary_out  output  WIDTH  decoded binary value
step_err  output  1  accepted code differed from the previous accepted code in a number of bits other than one
busy  output  1  high in DECODE and DONE states

Behaviour:
- Reset (rst_n low at an edge):
  - state IDLE, in_ready=1, out_valid=0, binary_out=0, step_err=0, busy=0.
  - Internal decode register=0, bit counter=0, prev_gray=0, prev_valid=0.
  - Reset overrides all other activity, including mid-decode; any in-flight code is discarded and no out_valid is produced for it.
- States: IDLE, DECODE, DONE. in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On an edge with in_valid && in_ready: capture gray_in into gray_reg, set counter=WIDTH-1, go to DECODE.
  - Compute err_next = prev_valid && (popcount(gray_in ^ prev_gray) != 1). Zero bits changed (identical code) is an error.
  - Update prev_gray=gray_in and prev_valid=1 on the same edge.
- DECODE, one edge per bit i, from WIDTH-1 down to 0:
  - bit WIDTH-1: dec[WIDTH-1] = gray_reg[WIDTH-1].
  - all other bits: dec[i] = dec[i+1] ^ gray_reg[i].
  - Counter decrements each edge.
  - On the edge that computes bit 0: load binary_out with the full decoded value, load step_err with err_next, set out_valid=1, go to DONE.
- Latency: accept at edge N, decode bits at edges N+1..N+WIDTH, out_valid visible after edge N+WIDTH.
- DONE:
  - out_valid, binary_out and step_err are held stable while out_ready=0, with no timeout.
  - On an edge with out_ready=1: out_valid=0, step_err=0, go to IDLE.
  - binary_out keeps its last value until the next result loads.
- in_valid is ignored outside IDLE. gray_in changes during DECODE have no effect.
- Maximum throughput is one code per WIDTH+2 cycles (out_ready tied high, in_valid held high).
- out_ready while out_valid=0 has no effect.
- The first code after reset never flags step_err.
- Wrap-around: the all-ones binary code and 0 are one Gray step apart. For WIDTH=4, Gray 1000 followed by Gray 0000 gives no error.

Test Plan:
- Reset, then single code gray_in=0011 (WIDTH=4), out_ready=1 -> out_valid rises exactly 4 edges after accept; binary_out=0010; step_err=0; in_ready low for 5 cycles.
- Stream gray 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100...1000 continuous -> binary 0000..1111 in order, step_err=0 throughout; then gray 0000 -> binary 0000, no error (wrap).
- After gray 0011, send gray 0110 (two bits changed) -> binary_out=0100, step_err=1. Then send gray 0110 again (zero change) -> step_err=1. Then send gray 0111 -> step_err=0, binary_out=0101.
- Backpressure: gray 1000 with out_ready=0 for 7 cycles -> out_valid, binary_out=1111 and step_err held stable; in_ready=0 and a new in_valid is ignored; out_ready=1 -> IDLE next edge.
- Reset mid-decode: accept gray 1111, assert rst_n=0 at the 2nd DECODE edge -> out_valid never rises; all outputs 0. Next code after reset gives step_err=0 regardless of value.
- Async-glitch check: pulse rst_n low between clock edges only -> no state change (synchronous reset).
